game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Top-level game-flow controller for the flappy-bird design. Sits between
//  the VGA sync generator / gamepad driver and the bird/pipe physics block.
//  Decides when physics runs: derives one update tick per frame, holds
//  physics in reset between games, and handles pause, death delay and
//  game-over timeout. Keeps the session high score.
// PARAMETERS
//  READY_FRAMES  60   frames in READY before auto-start (8-bit, 0..255)
//  DYING_FRAMES  30   frames frozen after collision before OVER
//  OVER_FRAMES   240  frames in OVER before falling back to ATTRACT
//  BLINK_FRAMES  16   frames per half-period of blink output
// PORTS
//  clk         in   1  system/pixel clock
//  rst_n       in   1  synchronous, active-low reset
//  vsync       in   1  vertical sync level from sync generator, clk domain
//  btn_start   in   1  START button level, active high, clk domain
//  btn_flap    in   1  flap button level, active high, clk domain
//  collision   in   1  physics collision/ground-hit level
//  score       in   8  current score from physics
//  frame_tick  out  1  one-cycle physics update strobe
//  flap_req    out  1  pending flap, consumed by physics on frame_tick
//  game_rst    out  1  synchronous reset for physics block, active high
//  state       out  3  current FSM state encoding
//  hi_score    out  8  best score since rst_n
//  new_record  out  1  last game set a new hi_score
//  blink       out  1  text-flash enable for ATTRACT/OVER screens
// BEHAVIOUR
//  - Edge detect: one register each on vsync, btn_start, btn_flap.
//    frame_edge = vsync & ~vsync_q; start_edge, flap_edge likewise.
//  - States: ATTRACT=0 READY=1 PLAY=2 PAUSE=3 DYING=4 OVER=5; 6,7 -> ATTRACT.
//  - Reset: state=ATTRACT, frame_tick=0, flap_req=0, game_rst=1,
//    hi_score=0, new_record=0, blink=0, counter=0, edge regs=0.
//  - game_rst=1 (registered) in ATTRACT and READY, else 0.
//  - ATTRACT: start_edge -> READY, cnt<=READY_FRAMES, new_record<=0.
//  - READY: frame_edge with cnt!=0 -> cnt-1; frame_edge with cnt==0 -> PLAY.
//    flap_edge -> PLAY immediately and sets flap_req.
//  - PLAY: frame_edge -> frame_tick=1 next cycle, exactly one cycle.
//    collision sampled only on frame_edge; if 1 -> DYING, cnt<=DYING_FRAMES,
//    no tick that frame. Else start_edge -> PAUSE (no tick that frame).
//    Priority in PLAY: collision > start_edge > tick.
//  - PAUSE: no ticks, flap_edge ignored; start_edge -> PLAY.
//  - DYING: count frames as READY; at cnt==0 on frame_edge -> OVER,
//    cnt<=OVER_FRAMES. start ignored.
//  - OVER: start_edge -> READY (cnt<=READY_FRAMES, new_record<=0);
//    else count frames, at cnt==0 on frame_edge -> ATTRACT.
//  - Param value 0: transition on first frame_edge in that state.
//  - flap_req <= (flap_req & ~frame_tick) | (flap_edge & state in READY/PLAY);
//    set wins over clear in same cycle; forced 0 outside READY/PLAY.
//  - hi_score: on PLAY->DYING transition, if score > hi_score (unsigned),
//    hi_score<=score and new_record<=1. Equal score: no update.
//  - blink: toggles every BLINK_FRAMES frame_edges in ATTRACT/OVER; 0 and
//    counter cleared in other states.
//  - state output is the registered state; all outputs registered.
//  - rst_n low mid-game: all regs return to reset values next edge,
//    hi_score included.
// TESTING
//  1 rst_n low 2 cycles -> state=0, game_rst=1, frame_tick=0, hi_score=0.
//  2 start pulse, READY_FRAMES=3 -> PLAY on 4th vsync rise; then one
//    1-cycle frame_tick per vsync rise, game_rst=0.
//  3 flap press in PLAY between vsyncs -> flap_req=1 until tick cycle, then 0;
//    held button gives no second request.
//  4 collision=1, score=7 at vsync rise -> no tick, DYING, hi_score=7,
//    new_record=1; score 5 next game -> hi_score stays 7, new_record=0.
//  5 start during PLAY -> PAUSE, zero ticks over 10 frames; start -> PLAY.
//  6 OVER idle OVER_FRAMES+1 frames -> ATTRACT, blink toggles every 16 frames;
//    collision and start same frame in PLAY -> DYING.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller for the flappy-bird design: frame strobe, physics reset,
// pause/death/game-over timing, flap request latching and session high score.
module game_sequencer #(
  parameter int unsigned READY_FRAMES = 60,
  parameter int unsigned DYING_FRAMES = 30,
  parameter int unsigned OVER_FRAMES  = 240,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_i,
  input  logic       btn_start_i,
  input  logic       btn_flap_i,
  input  logic       collision_i,
  input  logic [7:0] score_i,
  output logic       frame_tick_o,
  output logic       flap_req_o,
  output logic       game_rst_o,
  output logic [2:0] state_o,
  output logic [7:0] hi_score_o,
  output logic       new_record_o,
  output logic       blink_o
);

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_READY   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DYING   = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  localparam logic [7:0] READY_CNT = 8'(READY_FRAMES);
  localparam logic [7:0] DYING_CNT = 8'(DYING_FRAMES);
  localparam logic [7:0] OVER_CNT  = 8'(OVER_FRAMES);
  localparam logic [8:0] BLINK_LIM = 9'(BLINK_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic [7:0] hi_score_q, hi_score_d;
  logic       vsync_q, start_q, flap_q;
  logic       frame_tick_q, frame_tick_d;
  logic       flap_req_q, flap_req_d;
  logic       game_rst_q, game_rst_d;
  logic       new_record_q, new_record_d;
  logic       blink_q, blink_d;
  logic       frame_edge, start_edge, flap_edge;
  logic       in_game, blink_state;
  logic [8:0] blink_inc;

  assign frame_edge = vsync_i & ~vsync_q;
  assign start_edge = btn_start_i & ~start_q;
  assign flap_edge  = btn_flap_i & ~flap_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_tick_d = 1'b0;
    hi_score_d   = hi_score_q;
    new_record_d = new_record_q;
    case (state_q)
      ST_ATTRACT: begin
        if (start_edge) begin
          state_d      = ST_READY;
          cnt_d        = READY_CNT;
          new_record_d = 1'b0;
        end
      end
      ST_READY: begin
        if (flap_edge) begin
          state_d = ST_PLAY;
        end else if (frame_edge) begin
          if (cnt_q == 8'd0) state_d = ST_PLAY;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_PLAY: begin
        // Collision is only meaningful once physics has settled a frame.
        if (frame_edge && collision_i) begin
          state_d = ST_DYING;
          cnt_d   = DYING_CNT;
          if (score_i > hi_score_q) begin
            hi_score_d   = score_i;
            new_record_d = 1'b1;
          end
        end else if (start_edge) begin
          state_d = ST_PAUSE;
        end else if (frame_edge) begin
          frame_tick_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (start_edge) state_d = ST_PLAY;
      end
      ST_DYING: begin
        if (frame_edge) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_OVER;
            cnt_d   = OVER_CNT;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d      = ST_READY;
          cnt_d        = READY_CNT;
          new_record_d = 1'b0;
        end else if (frame_edge) begin
          if (cnt_q == 8'd0) state_d = ST_ATTRACT;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_ATTRACT;
    endcase

    // A new press wins over the tick that consumes the previous one.
    in_game    = (state_q == ST_READY) || (state_q == ST_PLAY);
    flap_req_d = in_game & ((flap_req_q & ~frame_tick_q) | flap_edge);

    blink_state = (state_q == ST_ATTRACT) || (state_q == ST_OVER);
    blink_inc   = {1'b0, blink_cnt_q} + 9'd1;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (!blink_state) begin
      blink_d     = 1'b0;
      blink_cnt_d = 8'd0;
    end else if (frame_edge) begin
      if (blink_inc >= BLINK_LIM) begin
        blink_d     = ~blink_q;
        blink_cnt_d = 8'd0;
      end else begin
        blink_cnt_d = blink_inc[7:0];
      end
    end

    game_rst_d = (state_d == ST_ATTRACT) || (state_d == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ATTRACT;
      cnt_q        <= 8'd0;
      blink_cnt_q  <= 8'd0;
      hi_score_q   <= 8'd0;
      vsync_q      <= 1'b0;
      start_q      <= 1'b0;
      flap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      flap_req_q   <= 1'b0;
      game_rst_q   <= 1'b1;
      new_record_q <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      hi_score_q   <= hi_score_d;
      vsync_q      <= vsync_i;
      start_q      <= btn_start_i;
      flap_q       <= btn_flap_i;
      frame_tick_q <= frame_tick_d;
      flap_req_q   <= flap_req_d;
      game_rst_q   <= game_rst_d;
      new_record_q <= new_record_d;
      blink_q      <= blink_d;
    end
  end

  assign frame_tick_o = frame_tick_q;
  assign flap_req_o   = flap_req_q;
  assign game_rst_o   = game_rst_q;
  assign state_o      = state_q;
  assign hi_score_o   = hi_score_q;
  assign new_record_o = new_record_q;
  assign blink_o      = blink_q;

endmodule
